// File: rtl/mmio_hub.sv
// Memory-mapped IO hub: LED banks and a synchronised switch port behind a fixed-latency request/ack bus.
// Optional switch debounce filter is enabled by defining SWITCH_DEBOUNCE_EN.
module mmio_hub #(
  parameter int                DATA_W    = 32,
  parameter int                SW_W      = 16,
  parameter int                LED_W     = 16,
  parameter int                N_LED     = 2,
  parameter logic [DATA_W-1:0] BASE_ADDR = 32'hFFFFFC00,
  parameter int                DB_CYCLES = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   io_req,
  input  logic                   io_we,
  input  logic [DATA_W-1:0]      io_addr,
  input  logic [DATA_W-1:0]      io_wdata,
  output logic                   io_ack,
  output logic                   io_err,
  output logic [DATA_W-1:0]      io_rdata,
  input  logic [SW_W-1:0]        switches,
  output logic [N_LED*LED_W-1:0] led_out
);

  localparam logic [DATA_W-1:0] LED_OFF = DATA_W'(32'h0000_0060);
  localparam logic [DATA_W-1:0] SW_OFF  = DATA_W'(32'h0000_0070);

  typedef enum logic {ST_IDLE = 1'b0, ST_RESP = 1'b1} state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic                     w_accept;
  logic [DATA_W-1:0]        w_off;
  logic [DATA_W-1:0]        w_word_off;
  logic                     w_led_hit;
  logic [LED_W-1:0]         w_led_rd;
  logic [N_LED-1:0]         w_led_sel;
  logic                     w_sw_hit;
  logic                     w_err;
  logic [DATA_W-1:0]        w_rd_val;
  logic                     r_ack;
  logic                     r_err;
  logic [DATA_W-1:0]        r_rdata;
  logic [N_LED*LED_W-1:0]   r_led;
  logic [SW_W-1:0]          r_sync1;
  logic [SW_W-1:0]          r_sync2;
  logic [SW_W-1:0]          w_filt;
  logic                     w_unused;

  // Decode on the word-aligned offset so misaligned hits on mapped words are flagged rather than treated as unmapped.
  assign w_off      = io_addr - BASE_ADDR;
  assign w_word_off = {w_off[DATA_W-1:2], 2'b00};
  assign w_sw_hit   = (w_word_off == SW_OFF);
  assign w_unused   = ^{io_wdata, w_off[1:0]};

  // LED bank decode and read mux.
  always_comb begin
    w_led_hit = 1'b0;
    w_led_rd  = '0;
    w_led_sel = '0;
    for (int k = 0; k < N_LED; k++) begin
      if (w_word_off == (LED_OFF + DATA_W'(4 * k))) begin
        w_led_hit    = 1'b1;
        w_led_sel[k] = 1'b1;
        w_led_rd     = r_led[k*LED_W +: LED_W];
      end else begin
        w_led_sel[k] = 1'b0;
      end
    end
  end

  // Error classification and captured read value.
  always_comb begin
    w_err    = 1'b0;
    w_rd_val = '0;
    if (!(w_led_hit || w_sw_hit) || (io_addr[1:0] != 2'b00) || (w_sw_hit && io_we)) begin
      w_err = 1'b1;
    end else if (io_we) begin
      w_rd_val = '0;
    end else if (w_led_hit) begin
      w_rd_val = DATA_W'(w_led_rd);
    end else begin
      w_rd_val = DATA_W'(w_filt);
    end
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next state; RESP always falls back to IDLE so requests are spaced at least two cycles apart.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (io_req) begin
          w_next   = ST_RESP;
          w_accept = 1'b1;
        end else begin
          w_next   = ST_IDLE;
        end
      end
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Response registers: loaded on accept, cleared in every other cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else if (w_accept) begin
      r_ack   <= 1'b1;
      r_err   <= w_err;
      r_rdata <= w_rd_val;
    end else begin
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end
  end

  // LED bank storage; only the low LED_W bits of the write data are kept.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_led <= '0;
    end else begin
      for (int k = 0; k < N_LED; k++) begin
        if (w_accept && io_we && !w_err && w_led_sel[k]) begin
          r_led[k*LED_W +: LED_W] <= io_wdata[LED_W-1:0];
        end
      end
    end
  end

  // Two-flop synchroniser for the asynchronous switch inputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= switches;
      r_sync2 <= r_sync1;
    end
  end

`ifdef SWITCH_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DB_CYCLES + 1);

  logic [SW_W-1:0]  r_sync_prev;
  logic [CNT_W-1:0] r_db_cnt;
  logic [SW_W-1:0]  r_filt;

  // Debounce: the filter tracks the synchronised vector only once it has held still for DB_CYCLES cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync_prev <= '0;
      r_db_cnt    <= '0;
      r_filt      <= '0;
    end else begin
      r_sync_prev <= r_sync2;
      if (r_sync2 != r_sync_prev) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt != CNT_W'(DB_CYCLES)) begin
        r_db_cnt <= r_db_cnt + CNT_W'(1);
      end else begin
        r_db_cnt <= r_db_cnt;
      end
      if (r_db_cnt == CNT_W'(DB_CYCLES)) begin
        r_filt <= r_sync_prev;
      end else begin
        r_filt <= r_filt;
      end
    end
  end

  assign w_filt = r_filt;
`else
  assign w_filt = r_sync2;
`endif

  assign io_ack   = r_ack;
  assign io_err   = r_err;
  assign io_rdata = r_rdata;
  assign led_out  = r_led;

endmodule

// File: tb/tb_mmio_hub.sv
// Scoreboard bench for mmio_hub: each access pushes its expected response, popped when io_ack arrives.
module tb_mmio_hub;

  localparam logic [31:0] BASE = 32'hFFFFFC00;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_req;
  logic        io_we;
  logic [31:0] io_addr;
  logic [31:0] io_wdata;
  logic        io_ack;
  logic        io_err;
  logic [31:0] io_rdata;
  logic [15:0] switches;
  logic [31:0] led_out;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_led = 32'h0;

  mmio_hub dut (
    .clock    (clock),
    .reset    (reset),
    .io_req   (io_req),
    .io_we    (io_we),
    .io_addr  (io_addr),
    .io_wdata (io_wdata),
    .io_ack   (io_ack),
    .io_err   (io_err),
    .io_rdata (io_rdata),
    .switches (switches),
    .led_out  (led_out)
  );

  always #5 clock = ~clock;

  // One access starting at a negedge; returns at a negedge with the FSM back in IDLE.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic exp_err, input logic [31:0] exp_rdata, input string name);
    exp_t e;
    int   waited;
    sb_q.push_back('{err: exp_err, rdata: exp_rdata});
    io_req = 1'b1; io_we = we; io_addr = addr; io_wdata = wdata;
    @(negedge clock);
    io_req = 1'b0;
    waited = 1;
    while (!io_ack && waited < 4) begin
      @(negedge clock);
      waited++;
    end
    e = sb_q.pop_front();
    checks++;
    if (io_ack !== 1'b1 || waited != 1) begin
      errors++;
      $display("FAIL %s_latency: ack=%b after %0d cycles, required ack=1 after 1 cycle", name, io_ack, waited);
    end
    checks++;
    if (io_err !== e.err || io_rdata !== e.rdata) begin
      errors++;
      $display("FAIL %s_resp: err=%b rdata=%h, required err=%b rdata=%h", name, io_err, io_rdata, e.err, e.rdata);
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1; io_req = 1'b0; io_we = 1'b0; io_addr = 32'h0; io_wdata = 32'h0; switches = 16'h0;
    repeat (3) @(negedge clock);
    checks++;
    if (io_ack !== 1'b0 || io_err !== 1'b0 || io_rdata !== 32'h0 || led_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: ack=%b err=%b rdata=%h led=%h, required all 0", io_ack, io_err, io_rdata, led_out);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_led_rw();
    access(1'b1, BASE + 32'h60, 32'h0000ABCD, 1'b0, 32'h0, "wr_led0");
    exp_led[15:0] = 16'hABCD;
    checks++;
    if (led_out !== exp_led) begin
      errors++;
      $display("FAIL led0_value: led=%h, required %h", led_out, exp_led);
    end
    access(1'b0, BASE + 32'h60, 32'h0, 1'b0, 32'h0000ABCD, "rd_led0");
  endtask

  task automatic test_bank1_unmapped();
    access(1'b1, BASE + 32'h64, 32'hDEAD1234, 1'b0, 32'h0, "wr_led1");
    exp_led[31:16] = 16'h1234;
    checks++;
    if (led_out !== 32'h1234ABCD) begin
      errors++;
      $display("FAIL led_both: led=%h, required 1234abcd", led_out);
    end
    access(1'b0, BASE + 32'h64, 32'h0, 1'b0, 32'h00001234, "rd_led1");
    access(1'b1, BASE + 32'h68, 32'h00005555, 1'b1, 32'h0, "wr_unmapped");
    access(1'b0, BASE + 32'h68, 32'h0, 1'b1, 32'h0, "rd_unmapped");
    access(1'b0, 32'h00001060, 32'h0, 1'b1, 32'h0, "rd_far");
    checks++;
    if (led_out !== exp_led) begin
      errors++;
      $display("FAIL led_after_unmapped: led=%h, required %h", led_out, exp_led);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   acks = 0;
    for (int i = 0; i < 3; i++) sb_q.push_back('{err: 1'b0, rdata: 32'h0});
    io_req = 1'b1; io_we = 1'b1; io_addr = BASE + 32'h60; io_wdata = 32'h00005A5A;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      checks++;
      if (io_ack !== ((i % 2) == 0)) begin
        errors++;
        $display("FAIL b2b_pattern: cycle %0d ack=%b, required %b", i, io_ack, ((i % 2) == 0));
      end
      if (io_ack === 1'b1) begin
        acks++;
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          checks++;
          if (io_err !== e.err || io_rdata !== e.rdata) begin
            errors++;
            $display("FAIL b2b_resp: err=%b rdata=%h, required err=%b rdata=%h", io_err, io_rdata, e.err, e.rdata);
          end
        end
      end
    end
    io_req = 1'b0;
    while (sb_q.size() > 0) e = sb_q.pop_front();
    exp_led[15:0] = 16'h5A5A;
    checks++;
    if (acks != 3) begin
      errors++;
      $display("FAIL b2b_count: acks=%0d, required 3", acks);
    end
    @(negedge clock);
    checks++;
    if (io_ack !== 1'b0 || led_out !== exp_led) begin
      errors++;
      $display("FAIL b2b_end: ack=%b led=%h, required ack=0 led=%h", io_ack, led_out, exp_led);
    end
  endtask

  task automatic test_switches();
`ifdef SWITCH_DEBOUNCE_EN
    for (int t = 0; t < 4; t++) begin
      switches = 16'h00F0;
      repeat (5) @(negedge clock);
      switches = 16'h0000;
      repeat (5) @(negedge clock);
    end
    switches = 16'h00F0;
    repeat (8) @(negedge clock);
    access(1'b0, BASE + 32'h70, 32'h0, 1'b0, 32'h0, "sw_unstable");
    repeat (20) @(negedge clock);
    access(1'b0, BASE + 32'h70, 32'h0, 1'b0, 32'h000000F0, "sw_stable");
`else
    switches = 16'h00F0;
    @(negedge clock);
    access(1'b0, BASE + 32'h70, 32'h0, 1'b0, 32'h0, "sw_early");
    switches = 16'h0000;
    repeat (4) @(negedge clock);
    switches = 16'h00F0;
    repeat (2) @(negedge clock);
    access(1'b0, BASE + 32'h70, 32'h0, 1'b0, 32'h000000F0, "sw_2cyc");
`endif
  endtask

  task automatic test_errors();
    access(1'b1, BASE + 32'h70, 32'h0000FFFF, 1'b1, 32'h0, "wr_switch");
    access(1'b1, BASE + 32'h62, 32'h0000FFFF, 1'b1, 32'h0, "wr_misaligned");
    access(1'b0, BASE + 32'h61, 32'h0, 1'b1, 32'h0, "rd_misaligned");
    checks++;
    if (led_out !== exp_led) begin
      errors++;
      $display("FAIL led_after_err: led=%h, required %h", led_out, exp_led);
    end
    access(1'b0, BASE + 32'h70, 32'h0, 1'b0, 32'h000000F0, "sw_after_err");
  endtask

  task automatic test_reset_in_resp();
    io_req = 1'b1; io_we = 1'b1; io_addr = BASE + 32'h60; io_wdata = 32'h0000FFFF;
    @(negedge clock);
    io_req = 1'b0;
    checks++;
    if (io_ack !== 1'b1 || led_out[15:0] !== 16'hFFFF) begin
      errors++;
      $display("FAIL resp_before_reset: ack=%b led0=%h, required ack=1 led0=ffff", io_ack, led_out[15:0]);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    exp_led = 32'h0;
    checks++;
    if (io_ack !== 1'b0 || led_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_abort: ack=%b led=%h, required ack=0 led=0", io_ack, led_out);
    end
    @(negedge clock);
  endtask

  task automatic test_req_in_reset();
    reset = 1'b1; io_req = 1'b1; io_we = 1'b1; io_addr = BASE + 32'h64; io_wdata = 32'h00007777;
    @(negedge clock);
    reset = 1'b0; io_req = 1'b0;
    @(negedge clock);
    checks++;
    if (io_ack !== 1'b0 || led_out !== 32'h0) begin
      errors++;
      $display("FAIL req_in_reset: ack=%b led=%h, required ack=0 led=0", io_ack, led_out);
    end
    access(1'b0, BASE + 32'h64, 32'h0, 1'b0, 32'h0, "rd_after_reset");
  endtask

  initial begin
    test_reset();
    test_led_rw();
    test_bank1_unmapped();
    test_back_to_back();
    test_switches();
    test_errors();
    test_reset_in_resp();
    test_req_in_reset();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
